// File: rtl/shared_memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// shared_memory_arbiter_if
//   Bundles the requester handshake and the external memory control strobes
//   of the shared memory arbiter.
//
//   NUM_REQ must match the NUM_REQ of the arbiter bound to this interface.
//
//   Signals:
//     req        [NUM_REQ] per-requester access request, level, held until ack
//     write      [NUM_REQ] per-requester direction (1 = write), sampled with grant
//     grant      [NUM_REQ] one-hot owner of the memory port
//     ack        [NUM_REQ] one-clock completion pulse to the granted requester
//     memSelect            memory chip select, active high
//     memRead              read strobe
//     memWrite             write strobe
//     memRefresh           refresh strobe
//     busy                 arbiter is not idle
//
//   Modports:
//     master : requester side (drives req/write, observes the rest)
//     slave  : arbiter side
// ---------------------------------------------------------------------------
interface shared_memory_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] write;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ack;
  logic               memSelect;
  logic               memRead;
  logic               memWrite;
  logic               memRefresh;
  logic               busy;

  modport master (
    output req, write,
    input  grant, ack, memSelect, memRead, memWrite, memRefresh, busy
  );

  modport slave (
    input  req, write,
    output grant, ack, memSelect, memRead, memWrite, memRefresh, busy
  );
endinterface

// File: rtl/shared_memory_arbiter.sv
// ---------------------------------------------------------------------------
// shared_memory_arbiter
//   Sequences the single external memory port and shares it round-robin
//   between NUM_REQ requesters. Refresh cycles are inserted autonomously from
//   a free-running timer and take priority over requests at the next idle
//   point. The module owns only the memory control strobes; address/data
//   steering is done outside using the one-hot grant.
//
//   Ports:
//     clk     system clock, rising edge
//     nReset  asynchronous active-low reset; aborts any access immediately
//     bus     shared_memory_arbiter_if.slave (req/write in, grant/ack/strobes out)
//
//   Sequence:  IDLE -> ACCESS (ACCESS_CYCLES) -> RECOVER -> IDLE
//              IDLE -> REFRESH (REFRESH_CYCLES) -> RECOVER -> IDLE
// ---------------------------------------------------------------------------
module shared_memory_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ACCESS_CYCLES  = 4,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 6
) (
  input  logic                    clk,
  input  logic                    nReset,
  shared_memory_arbiter_if.slave  bus
);

  // Phase counter is shared by ACCESS and REFRESH, so size it for the longer one.
  localparam int PH_MAX = (ACCESS_CYCLES > REFRESH_CYCLES) ? ACCESS_CYCLES : REFRESH_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam int RC_W   = $clog2(REFRESH_PERIOD);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [PH_W-1:0]  ACC_LAST   = PH_W'(ACCESS_CYCLES - 1);
  localparam logic [PH_W-1:0]  REF_LAST   = PH_W'(REFRESH_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_RELOAD  = RC_W'(REFRESH_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_REFRESH,
    ST_RECOVER
  } state_e;

  state_e             state_q,   state_d;
  logic [PH_W-1:0]    phase_q,   phase_d;
  logic [RC_W-1:0]    rcnt_q,    rcnt_d;
  logic               pending_q, pending_d;
  logic [IDX_W-1:0]   last_q,    last_d;
  logic [NUM_REQ-1:0] grant_q,   grant_d;
  logic               wr_q,      wr_d;

  logic               expire;
  logic               enter_refresh;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;

  // -------------------------------------------------------------------------
  // Refresh timer: free-running down-counter. A pending refresh saturates;
  // entering REFRESH wins over a coincident expiry, which is then dropped
  // because the refresh it would request is already being served.
  // -------------------------------------------------------------------------
  assign expire = (rcnt_q == '0);

  always_comb begin
    rcnt_d    = expire ? RC_RELOAD : (rcnt_q - 1'b1);
    pending_d = pending_q;
    if (enter_refresh) begin
      pending_d = 1'b0;
    end else if (expire) begin
      pending_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pick: first asserted req scanning upward from last+1.
  // -------------------------------------------------------------------------
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!win_valid && bus.req[idx]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d       = state_q;
    phase_d       = phase_q;
    grant_d       = grant_q;
    wr_d          = wr_q;
    last_d        = last_q;
    enter_refresh = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Decision uses the registered pending flag, so an expiry in this
        // same clock cannot pre-empt an arbitration already under way.
        if (pending_q) begin
          state_d       = ST_REFRESH;
          phase_d       = '0;
          enter_refresh = 1'b1;
        end else if (win_valid) begin
          state_d = ST_ACCESS;
          phase_d = '0;
          grant_d = NUM_REQ'(1) << win_idx;
          wr_d    = bus.write[win_idx];
          last_d  = win_idx;
        end
      end

      ST_ACCESS: begin
        if (phase_q == ACC_LAST) begin
          state_d = ST_RECOVER;
          phase_d = '0;
          grant_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_REFRESH: begin
        if (phase_q == REF_LAST) begin
          state_d = ST_RECOVER;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_RECOVER: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        grant_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      rcnt_q    <= RC_RELOAD;
      pending_q <= 1'b0;
      last_q    <= LAST_RESET;
      grant_q   <= '0;
      wr_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      phase_q   <= phase_d;
      rcnt_q    <= rcnt_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      wr_q      <= wr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs are decoded from registers only, so they carry no path from the
  // request inputs and all fall together when nReset is asserted.
  // -------------------------------------------------------------------------
  logic in_access;
  logic acc_last_phase;

  assign in_access      = (state_q == ST_ACCESS);
  assign acc_last_phase = (phase_q == ACC_LAST);

  assign bus.grant      = grant_q;
  assign bus.ack        = (in_access && acc_last_phase) ? grant_q : '0;
  assign bus.memSelect  = in_access;
  assign bus.memRead    = in_access && !acc_last_phase && !wr_q;
  assign bus.memWrite   = in_access && !acc_last_phase &&  wr_q;
  assign bus.memRefresh = (state_q == ST_REFRESH);
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
